// File: rtl/rs_bank_pkg.sv
// rtl/rs_bank_pkg.sv - shared widths and entry/CDB types for the reservation-station bank
package rs_bank_pkg;

  localparam int ROB_TAG_W    = 5;
  localparam int RS_XLEN      = 32;
  localparam int RS_PAYLOAD_W = 64;

  typedef struct packed {
    logic valid;
    logic rdy1;
    logic rdy2;
  } rs_state_t;

  typedef struct packed {
    logic                 valid;
    logic [ROB_TAG_W-1:0] tag;
    logic [RS_XLEN-1:0]   value;
  } cdb_lane_t;

endpackage

// File: rtl/rs_bank_age_matrix.sv
// rtl/rs_bank_age_matrix.sv - DEPTHxDEPTH age matrix granting the oldest requester
module rs_age_matrix #(
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_flush,
  input  logic [DEPTH-1:0] i_alloc_oh,
  input  logic [DEPTH-1:0] i_free_oh,
  input  logic [DEPTH-1:0] i_valid,
  input  logic [DEPTH-1:0] i_req,
  output logic [DEPTH-1:0] o_grant
);

  // r_older[i][j] = 1 when entry j was allocated before entry i
  logic [DEPTH-1:0] r_older [DEPTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_older[i] <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) r_older[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_alloc_oh[i]) r_older[i] <= i_valid & ~i_free_oh;
        else               r_older[i] <= r_older[i] & ~i_free_oh;
      end
    end
  end

  always_comb begin
    o_grant = '0;
    for (int i = 0; i < DEPTH; i++)
      o_grant[i] = i_req[i] && ((r_older[i] & i_req) == '0);
  end

endmodule

// File: rtl/rs_bank.sv
// rtl/rs_bank.sv - reservation-station bank with CDB wakeup and age-ordered issue
module rs_bank
  import rs_bank_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int TAG_W     = ROB_TAG_W,
  parameter int XLEN      = RS_XLEN,
  parameter int NUM_CDB   = 2,
  parameter int PAYLOAD_W = RS_PAYLOAD_W,
  parameter int CNT_W     = $clog2(DEPTH+1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    dp_valid,
  output logic                    dp_ready,
  input  logic [TAG_W-1:0]        dp_rob_tag,
  input  logic [TAG_W-1:0]        dp_t1,
  input  logic [TAG_W-1:0]        dp_t2,
  input  logic                    dp_t1_ready,
  input  logic                    dp_t2_ready,
  input  logic [XLEN-1:0]         dp_v1,
  input  logic [XLEN-1:0]         dp_v2,
  input  logic [PAYLOAD_W-1:0]    dp_payload,
  input  logic [NUM_CDB-1:0]      cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0] cdb_value,
  output logic                    issue_valid,
  input  logic                    issue_ready,
  output logic [TAG_W-1:0]        issue_rob_tag,
  output logic [XLEN-1:0]         issue_v1,
  output logic [XLEN-1:0]         issue_v2,
  output logic [PAYLOAD_W-1:0]    issue_payload,
  output logic [CNT_W-1:0]        free_count
);

  localparam int IDX_W = $clog2(DEPTH);

  rs_state_t            r_st      [DEPTH];
  logic [TAG_W-1:0]     r_rob_tag [DEPTH];
  logic [TAG_W-1:0]     r_t1      [DEPTH];
  logic [TAG_W-1:0]     r_t2      [DEPTH];
  logic [XLEN-1:0]      r_v1      [DEPTH];
  logic [XLEN-1:0]      r_v2      [DEPTH];
  logic [PAYLOAD_W-1:0] r_payload [DEPTH];
  logic [CNT_W-1:0]     r_free_count;
  logic                 r_lock;
  logic [IDX_W-1:0]     r_lock_idx;

  logic [DEPTH-1:0] w_valid, w_req, w_grant, w_first_free, w_alloc_oh, w_free_oh;
  logic [DEPTH-1:0] w_wk1_hit, w_wk2_hit;
  logic [XLEN-1:0]  w_wk1_val [DEPTH];
  logic [XLEN-1:0]  w_wk2_val [DEPTH];
  logic             w_dp1_hit, w_dp2_hit, w_alloc_fire, w_issue_fire, w_found;
  logic [XLEN-1:0]  w_dp1_val, w_dp2_val;
  logic [IDX_W-1:0] w_grant_idx, w_sel_idx;

  assign dp_ready     = (r_free_count != '0);
  assign free_count   = r_free_count;
  assign w_alloc_fire = dp_valid && dp_ready && !flush;

  // Lanes are scanned high to low so the lowest matching lane wins.
  always_comb begin
    w_dp1_hit = 1'b0; w_dp1_val = '0;
    w_dp2_hit = 1'b0; w_dp2_val = '0;
    w_wk1_hit = '0;   w_wk2_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_wk1_val[i] = '0;
      w_wk2_val[i] = '0;
    end
    for (int l = NUM_CDB-1; l >= 0; l--) begin
      if (cdb_valid[l]) begin
        if (cdb_tag[l*TAG_W +: TAG_W] == dp_t1) begin
          w_dp1_hit = 1'b1; w_dp1_val = cdb_value[l*XLEN +: XLEN];
        end
        if (cdb_tag[l*TAG_W +: TAG_W] == dp_t2) begin
          w_dp2_hit = 1'b1; w_dp2_val = cdb_value[l*XLEN +: XLEN];
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (cdb_tag[l*TAG_W +: TAG_W] == r_t1[i]) begin
            w_wk1_hit[i] = 1'b1; w_wk1_val[i] = cdb_value[l*XLEN +: XLEN];
          end
          if (cdb_tag[l*TAG_W +: TAG_W] == r_t2[i]) begin
            w_wk2_hit[i] = 1'b1; w_wk2_val[i] = cdb_value[l*XLEN +: XLEN];
          end
        end
      end
    end
  end

  always_comb begin
    w_valid      = '0;
    w_req        = '0;
    w_first_free = '0;
    w_found      = 1'b0;
    w_grant_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_valid[i] = r_st[i].valid;
      w_req[i]   = r_st[i].valid && r_st[i].rdy1 && r_st[i].rdy2;
      if (!r_st[i].valid && !w_found) begin
        w_found         = 1'b1;
        w_first_free[i] = 1'b1;
      end
      if (w_grant[i]) w_grant_idx = IDX_W'(i);
    end
  end

  // A locked index keeps the packet stable until the FU accepts it.
  assign w_sel_idx    = r_lock ? r_lock_idx : w_grant_idx;
  assign issue_valid  = (r_lock || (w_req != '0)) && !flush;
  assign w_issue_fire = issue_valid && issue_ready;
  assign w_alloc_oh   = w_alloc_fire ? w_first_free : '0;
  assign w_free_oh    = w_issue_fire ? (DEPTH'(1) << w_sel_idx) : '0;

  assign issue_rob_tag = issue_valid ? r_rob_tag[w_sel_idx] : '0;
  assign issue_v1      = issue_valid ? r_v1[w_sel_idx]      : '0;
  assign issue_v2      = issue_valid ? r_v2[w_sel_idx]      : '0;
  assign issue_payload = issue_valid ? r_payload[w_sel_idx] : '0;

  rs_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clock      (clock),
    .reset      (reset),
    .i_flush    (flush),
    .i_alloc_oh (w_alloc_oh),
    .i_free_oh  (w_free_oh),
    .i_valid    (w_valid),
    .i_req      (w_req),
    .o_grant    (w_grant)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_st[i]      <= '0;
        r_rob_tag[i] <= '0;
        r_t1[i]      <= '0;
        r_t2[i]      <= '0;
        r_v1[i]      <= '0;
        r_v2[i]      <= '0;
        r_payload[i] <= '0;
      end
      r_free_count <= CNT_W'(DEPTH);
      r_lock       <= 1'b0;
      r_lock_idx   <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) r_st[i] <= '0;
      r_free_count <= CNT_W'(DEPTH);
      r_lock       <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_alloc_oh[i]) begin
          r_st[i].valid <= 1'b1;
          r_st[i].rdy1  <= dp_t1_ready || w_dp1_hit;
          r_st[i].rdy2  <= dp_t2_ready || w_dp2_hit;
          r_v1[i]       <= dp_t1_ready ? dp_v1 : w_dp1_val;
          r_v2[i]       <= dp_t2_ready ? dp_v2 : w_dp2_val;
          r_rob_tag[i]  <= dp_rob_tag;
          r_t1[i]       <= dp_t1;
          r_t2[i]       <= dp_t2;
          r_payload[i]  <= dp_payload;
        end else begin
          if (w_free_oh[i]) r_st[i].valid <= 1'b0;
          if (r_st[i].valid && !r_st[i].rdy1 && w_wk1_hit[i]) begin
            r_st[i].rdy1 <= 1'b1;
            r_v1[i]      <= w_wk1_val[i];
          end
          if (r_st[i].valid && !r_st[i].rdy2 && w_wk2_hit[i]) begin
            r_st[i].rdy2 <= 1'b1;
            r_v2[i]      <= w_wk2_val[i];
          end
        end
      end
      r_free_count <= r_free_count - CNT_W'(w_alloc_fire) + CNT_W'(w_issue_fire);
      if (w_issue_fire) begin
        r_lock <= 1'b0;
      end else if (issue_valid) begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_sel_idx;
      end
    end
  end

endmodule
